ssd_scroll_scheduler: RTL and testbench



---
 rtl/ssd_scroll_scheduler.sv | 157 +++++++++++++++
 tb/tb_ssd_scroll_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scroll_scheduler.sv
// ssd_scroll_scheduler
// Buffers decoded Morse characters (active-low seven-segment patterns) in a
// small FIFO. On each scroll tick one character is shifted into a 4-digit
// window, right to left. A window that sits idle past the hold time is blanked.
module ssd_scroll_scheduler #(
  parameter int FIFO_DEPTH = 8,          // power of two, >= 2
  parameter int SCROLL_DIV = 25000000,   // clk cycles per scroll tick, >= 2
  parameter int HOLD_TICKS = 8           // idle ticks before auto-blank, >= 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          char_valid,
  input  logic [7:0]                    char_seg,
  output logic                          char_ready,
  input  logic                          clear,
  input  logic                          freeze,
  output logic [31:0]                   cathode_config_combined,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SCROLL_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1) + 1;

  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] TICK_LAST = CW'(SCROLL_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  localparam logic [31:0] BLANK = 32'hFFFF_FFFF;

  // FIFO storage and pointers
  logic [FIFO_DEPTH-1:0][7:0] mem;
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic [AW:0]                count;

  // pacing and window state
  logic [CW-1:0]              tick_cnt;
  logic [HW-1:0]              hold_cnt;
  logic [1:0]                 state;
  logic [31:0]                window;

  logic full, nonempty, tick, push, pop;
  logic [7:0] head;

  assign full       = (count == DEPTH_C);
  assign nonempty   = (count != '0);
  assign head       = mem[rd_ptr];

  // Ready depends only on registered occupancy and the flush request, so a
  // full FIFO refuses a push even when a pop lands in the same cycle.
  assign char_ready = ~full & ~clear;
  assign push       = char_valid & char_ready;

  assign tick       = (tick_cnt == TICK_LAST) & ~freeze;
  // Pop looks at the registered occupancy, so a character arriving on the
  // tick cycle into an empty FIFO waits for the next tick.
  assign pop        = tick & nonempty & ~clear;

  assign cathode_config_combined = window;
  assign fifo_count              = count;
  assign busy                    = (state != ST_EMPTY) | nonempty;

  // character storage; contents need no reset, occupancy is tracked separately
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= char_seg;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // scroll tick divider; holds while frozen, restarts on clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (clear) begin
      tick_cnt <= '0;
    end else if (!freeze) begin
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
    end
  end

  // window shifting and idle/blank sequencing, advanced only on ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      window   <= BLANK;
      hold_cnt <= '0;
    end else if (clear) begin
      state    <= ST_EMPTY;
      window   <= BLANK;
      hold_cnt <= '0;
    end else if (tick) begin
      case (state)
        ST_EMPTY: begin
          if (nonempty) begin
            window <= {window[23:0], head};
            state  <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (nonempty) begin
            window <= {window[23:0], head};
          end else if (HOLD_TICKS == 1) begin
            window   <= BLANK;
            hold_cnt <= '0;
            state    <= ST_EMPTY;
          end else begin
            hold_cnt <= HW'(1);
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (nonempty) begin
            window   <= {window[23:0], head};
            hold_cnt <= '0;
            state    <= ST_ACTIVE;
          end else if (hold_cnt >= HOLD_MAX) begin
            window   <= BLANK;
            hold_cnt <= '0;
            state    <= ST_EMPTY;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_EMPTY;
          window   <= BLANK;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssd_scroll_scheduler.sv
// Bench for ssd_scroll_scheduler: constant-vector table, hand corner sequences,
// and a random run, every cycle checked against a queue-based reference model.
module tb_ssd_scroll_scheduler;

  localparam int DEPTH = 4;
  localparam int DIV   = 4;
  localparam int HOLD  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        char_valid = 1'b0;
  logic [7:0]  char_seg = 8'hFF;
  logic        char_ready;
  logic        clear = 1'b0;
  logic        freeze = 1'b0;
  logic [31:0] cathode_config_combined;
  logic [2:0]  fifo_count;
  logic        busy;

  int total = 0;
  int bad   = 0;

  ssd_scroll_scheduler #(.FIFO_DEPTH(DEPTH), .SCROLL_DIV(DIV), .HOLD_TICKS(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char_seg(char_seg),
    .char_ready(char_ready), .clear(clear), .freeze(freeze),
    .cathode_config_combined(cathode_config_combined),
    .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // reference model: FIFO as a queue, scroll phase, idle-tick count, mode
  logic [7:0]  q[$];
  logic [31:0] m_win;
  int          m_phase, m_idle, m_mode;   // mode: 0 empty, 1 showing, 2 idle-held
  logic        last_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_win = 32'hFFFF_FFFF; m_phase = 0; m_idle = 0; m_mode = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] s, input logic clr, input logic frz);
    logic take, tk;
    take = v && !clr && (q.size() != DEPTH);
    tk   = !frz && (m_phase == DIV - 1);
    if (clr) begin
      model_reset();
      return;
    end
    if (!frz) m_phase = (m_phase + 1) % DIV;
    if (tk) begin
      if (q.size() != 0) begin
        m_win  = {m_win[23:0], q.pop_front()};
        m_mode = 1; m_idle = 0;
      end else if (m_mode == 1) begin
        m_mode = 2; m_idle = 1;
      end else if (m_mode == 2) begin
        if (m_idle >= HOLD) begin
          m_win = 32'hFFFF_FFFF; m_mode = 0; m_idle = 0;
        end else m_idle++;
      end
    end
    if (take) q.push_back(s);
  endtask

  // one clock cycle: drive, check ready before the edge, clock, check outputs
  task automatic cyc(input logic v, input logic [7:0] s, input logic clr, input logic frz);
    char_valid = v; char_seg = s; clear = clr; freeze = frz;
    #1;
    last_ready = char_ready;
    chk("ready", {31'd0, char_ready}, {31'd0, (q.size() != DEPTH) && !clr});
    @(posedge clk);
    model_step(v, s, clr, frz);
    #1;
    chk("window", cathode_config_combined, m_win);
    chk("count", {29'd0, fifo_count}, 32'(q.size()));
    chk("busy", {31'd0, busy}, {31'd0, (m_mode != 0) || (q.size() != 0)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'hFF, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    char_valid = 1'b0; clear = 1'b0; freeze = 1'b0; char_seg = 8'hFF;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("rst_window", cathode_config_combined, 32'hFFFF_FFFF);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, char_ready}, 32'd1);
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  seg;
    int          reps;
    logic [31:0] win;
    logic [2:0]  cnt;
    logic        busy;
  } vec_t;

  vec_t tbl[10];
  logic [7:0] af[6];
  logic [31:0] snap;

  initial begin
    // scenario: three back-to-back pushes scroll in, then hold and blank
    tbl[0] = '{1'b1, 8'hC0, 1, 32'hFFFF_FFFF, 3'd1, 1'b1};
    tbl[1] = '{1'b1, 8'hF9, 1, 32'hFFFF_FFFF, 3'd2, 1'b1};
    tbl[2] = '{1'b1, 8'hA4, 1, 32'hFFFF_FFFF, 3'd3, 1'b1};
    tbl[3] = '{1'b0, 8'hFF, 1, 32'hFFFF_FFC0, 3'd2, 1'b1};
    tbl[4] = '{1'b0, 8'hFF, 4, 32'hFFFF_C0F9, 3'd1, 1'b1};
    tbl[5] = '{1'b0, 8'hFF, 4, 32'hFFC0_F9A4, 3'd0, 1'b1};
    tbl[6] = '{1'b0, 8'hFF, 4, 32'hFFC0_F9A4, 3'd0, 1'b1};
    tbl[7] = '{1'b0, 8'hFF, 4, 32'hFFC0_F9A4, 3'd0, 1'b1};
    tbl[8] = '{1'b0, 8'hFF, 3, 32'hFFC0_F9A4, 3'd0, 1'b1};
    tbl[9] = '{1'b0, 8'hFF, 1, 32'hFFFF_FFFF, 3'd0, 1'b0};
    af = '{8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    do_reset();
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < tbl[r].reps; k++) cyc(tbl[r].v, tbl[r].seg, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_win", r), cathode_config_combined, tbl[r].win);
      chk($sformatf("tbl%0d_cnt", r), {29'd0, fifo_count}, {29'd0, tbl[r].cnt});
      chk($sformatf("tbl%0d_busy", r), {31'd0, busy}, {31'd0, tbl[r].busy});
    end

    // six characters over time: window keeps the last four, then idles out
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, af[k], 1'b0, 1'b0);
      idle(3);
    end
    chk("six_win", cathode_config_combined, {af[2], af[3], af[4], af[5]});
    idle(8);
    chk("six_hold_win", cathode_config_combined, {af[2], af[3], af[4], af[5]});
    chk("six_hold_busy", {31'd0, busy}, 32'd1);
    idle(4);
    chk("six_blank_win", cathode_config_combined, 32'hFFFF_FFFF);
    chk("six_blank_busy", {31'd0, busy}, 32'd0);

    // full FIFO: fifth push waits until the cycle after the first pop
    do_reset();
    for (int k = 0; k < 5; k++) cyc(1'b1, af[k], 1'b0, 1'b1);
    chk("full_cnt", {29'd0, fifo_count}, 32'd4);
    chk("full_ready", {31'd0, char_ready}, 32'd0);
    for (int k = 0; k < 3; k++) cyc(1'b1, af[4], 1'b0, 1'b0);
    chk("full_wait_cnt", {29'd0, fifo_count}, 32'd4);
    cyc(1'b1, af[4], 1'b0, 1'b0);
    chk("full_pop_cnt", {29'd0, fifo_count}, 32'd3);
    chk("full_pop_win", cathode_config_combined, {24'hFFFFFF, af[0]});
    chk("full_pop_ready", {31'd0, char_ready}, 32'd1);
    cyc(1'b1, af[4], 1'b0, 1'b0);
    chk("full_take5_cnt", {29'd0, fifo_count}, 32'd4);
    idle(2);

    // freeze with two queued: nothing moves, pushes still land
    do_reset();
    cyc(1'b1, 8'hC0, 1'b0, 1'b0);
    cyc(1'b1, 8'hF9, 1'b0, 1'b0);
    cyc(1'b1, 8'hA4, 1'b0, 1'b0);
    cyc(1'b0, 8'hFF, 1'b0, 1'b0);
    snap = cathode_config_combined;
    chk("frz_pre_cnt", {29'd0, fifo_count}, 32'd2);
    cyc(1'b1, 8'h99, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) cyc(1'b0, 8'hFF, 1'b0, 1'b1);
    chk("frz_win", cathode_config_combined, snap);
    chk("frz_cnt", {29'd0, fifo_count}, 32'd3);
    idle(3);
    chk("frz_rel_win_still", cathode_config_combined, snap);
    idle(1);
    chk("frz_rel_win", cathode_config_combined, 32'hFFFF_C0F9);
    chk("frz_rel_cnt", {29'd0, fifo_count}, 32'd2);

    // clear with three queued and a push pending
    do_reset();
    cyc(1'b1, 8'hC0, 1'b0, 1'b0);
    cyc(1'b1, 8'hF9, 1'b0, 1'b0);
    cyc(1'b1, 8'hA4, 1'b0, 1'b0);
    cyc(1'b1, 8'hB0, 1'b0, 1'b0);
    chk("clr_pre_cnt", {29'd0, fifo_count}, 32'd3);
    cyc(1'b1, 8'h99, 1'b1, 1'b0);
    chk("clr_ready", {31'd0, last_ready}, 32'd0);
    chk("clr_cnt", {29'd0, fifo_count}, 32'd0);
    chk("clr_win", cathode_config_combined, 32'hFFFF_FFFF);
    chk("clr_busy", {31'd0, busy}, 32'd0);
    idle(6);

    // asynchronous reset between edges while showing characters
    do_reset();
    cyc(1'b1, 8'hC0, 1'b0, 1'b0);
    cyc(1'b1, 8'hF9, 1'b0, 1'b0);
    idle(3);
    chk("arst_pre_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_win", cathode_config_combined, 32'hFFFF_FFFF);
    chk("arst_cnt", {29'd0, fifo_count}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    do_reset();

    // random traffic against the model
    for (int k = 0; k < 600; k++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom),
          ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 10));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
